// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port 8K x 8 memory with registered read and level-sensitive write.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration; fixed priority (port 0 first) otherwise.
module mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] addressMem,
    output logic [DATA_W-1:0] dataMem,
    input  logic [DATA_W-1:0] memOut
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DONE = 3'd2,
        WR      = 3'd3,
        WR_DONE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                grant_s, win_s, win_we_s, done_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_data_s;
    logic                gnt_q, gnt_d;
    logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d, rdata_q, rdata_d;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Round-robin winner: on a tie the port not granted last time wins.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~last_q;
        end else if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
        last_d = grant_s ? win_s : last_q;
    end

    // Last-grant pointer; reset reads as "port 1 last" so port 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it requests.
    always_comb begin
        win_s = ~req0;
    end
`endif

    // Grant qualification and winner's request fields.
    always_comb begin
        grant_s    = (state_q == IDLE) && (req0 || req1);
        win_we_s   = win_s ? we1 : we0;
        win_addr_s = win_s ? addr1 : addr0;
        win_data_s = win_s ? wdata1 : wdata0;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = win_we_s ? WR : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD:      state_d = RD_DONE;
            RD_DONE: state_d = IDLE;
            WR:      state_d = WR_DONE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; memory address/data move only on a grant.
    always_comb begin
        mem_read_d  = (state_d == RD);
        mem_write_d = (state_d == WR);
        busy_d      = (state_d != IDLE);
        done_s      = (state_q == RD_DONE) || (state_q == WR_DONE);
        ack0_d      = done_s && !gnt_q;
        ack1_d      = done_s && gnt_q;
        rdata_d     = (state_q == RD_DONE) ? memOut : rdata_q;
        if (grant_s) begin
            addr_d = win_addr_s;
            data_d = win_data_s;
            gnt_d  = win_s;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
            gnt_d  = gnt_q;
        end
    end

    // Output registers; a reset that lands while memWrite is high keeps the address/data steady for that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            gnt_q       <= 1'b0;
            if (mem_write_q) begin
                addr_q <= addr_q;
                data_q <= data_q;
            end else begin
                addr_q <= {ADDR_W{1'b0}};
                data_q <= {DATA_W{1'b0}};
            end
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign memRead    = mem_read_q;
    assign memWrite   = mem_write_q;
    assign addressMem = addr_q;
    assign dataMem    = data_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign busy       = busy_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level scheduling/shadow-memory reference model.
// Build with the same MEM_ARB_RR_EN setting as the design.
module tb_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic              clock, reset;
    logic              req0, we0, ack0, req1, we1, ack1;
    logic [ADDR_W-1:0] addr0, addr1, addressMem;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, dataMem, memOut;
    logic              busy, memRead, memWrite;

    int checks   = 0;
    int failures = 0;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [7:0]  shadow [0:8191];
    bit          model_last;
    logic [7:0]  last_rd;
    bit          rd_known;

    logic [7:0]  mem_w [0:8191];
    bit          mem_v [0:8191];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .memRead(memRead), .memWrite(memWrite),
        .addressMem(addressMem), .dataMem(dataMem), .memOut(memOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory preload pattern: address 1000 holds 40, 1001 holds 41, ...
    function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo - 8'd192;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [ADDR_W-1:0] a);
        return mem_v[a] ? mem_w[a] : init_val(a);
    endfunction

    // Memory model: registered read, write captured while memWrite is high.
    always @(posedge clock) begin
        if (memRead) memOut <= mem_rd(addressMem);
        if (memWrite) begin
            mem_w[addressMem] <= dataMem;
            mem_v[addressMem] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i0, input int i1);
        if (i0 < q0.size()) begin
            req0 = 1'b1; we0 = q0[i0].we; addr0 = q0[i0].addr; wdata0 = q0[i0].data;
        end else begin
            req0 = 1'b0;
        end
        if (i1 < q1.size()) begin
            req1 = 1'b1; we1 = q1[i1].we; addr1 = q1[i1].addr; wdata1 = q1[i1].data;
        end else begin
            req1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_last = 1'b1;
        last_rd = 8'd0;
        rd_known = 1'b1;
    endtask

    // Serve everything queued in q0/q1; the model decides service order and read data, one access per 3 cycles.
    task automatic run_seq();
        txn_t       a0[$];
        txn_t       a1[$];
        int         s_port[$];
        txn_t       s_txn[$];
        logic [7:0] s_exp[$];
        txn_t       tx;
        int         w, i0, i1, n, k, ph, p;
        logic       prev_mw;
        logic [ADDR_W-1:0] prev_addr;
        a0 = q0; a1 = q1;
        while (a0.size() > 0 || a1.size() > 0) begin
            if (a0.size() > 0 && a1.size() > 0) begin
`ifdef MEM_ARB_RR_EN
                w = model_last ? 0 : 1;
`else
                w = 0;
`endif
            end else if (a0.size() > 0) begin
                w = 0;
            end else begin
                w = 1;
            end
            model_last = (w == 1);
            s_port.push_back(w);
            if (w == 0) begin tx = a0.pop_front(); end else begin tx = a1.pop_front(); end
            s_txn.push_back(tx);
            if (tx.we) begin
                shadow[tx.addr] = tx.data;
                s_exp.push_back(8'd0);
            end else begin
                s_exp.push_back(shadow[tx.addr]);
            end
        end
        n = s_port.size();
        i0 = 0; i1 = 0;
        drive(i0, i1);
        prev_mw = memWrite; prev_addr = addressMem;
        for (int t = 1; t <= 3 * n; t++) begin
            tick();
            k = (t - 1) / 3; ph = (t - 1) % 3;
            tx = s_txn[k]; p = s_port[k];
            check("memRead", memRead, (ph == 0) && !tx.we);
            check("memWrite", memWrite, (ph == 0) && tx.we);
            check("busy", busy, ph != 2);
            check("ack0", ack0, (ph == 2) && (p == 0));
            check("ack1", ack1, (ph == 2) && (p == 1));
            check("addressMem", addressMem, tx.addr);
            check("dataMem", dataMem, tx.data);
            if (prev_mw) check("addr_stable_wr", addressMem, prev_addr);
            if (ph == 2 && !tx.we) begin
                check("rdata_ack", rdata, s_exp[k]);
                last_rd = s_exp[k];
                rd_known = 1'b1;
            end else if (ph == 2) begin
                rd_known = 1'b0;
            end else if (rd_known) begin
                check("rdata_hold", rdata, last_rd);
            end
            if (ph == 2) begin
                if (p == 0) i0++; else i1++;
                drive(i0, i1);
            end
            prev_mw = memWrite; prev_addr = addressMem;
        end
        q0.delete();
        q1.delete();
    endtask

    function automatic txn_t mk(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        txn_t x;
        x.we = we; x.addr = a; x.data = d;
        return x;
    endfunction

    initial begin
        int n0, n1;
        for (int i = 0; i < 8192; i++) shadow[i] = init_val(i[ADDR_W-1:0]);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        do_reset();
        check("rst_memRead", memRead, 1'b0);
        check("rst_memWrite", memWrite, 1'b0);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 8'd0);
        check("rst_addressMem", addressMem, 13'd0);
        check("rst_dataMem", dataMem, 8'd0);

        // Read after reset on port 1.
        q1.push_back(mk(1'b0, 13'd1000, 8'h00));
        run_seq();
        // Write then read on port 0, request held across the ack.
        q0.push_back(mk(1'b1, 13'd2000, 8'hA5));
        q0.push_back(mk(1'b0, 13'd2000, 8'h00));
        run_seq();
        // Simultaneous requests.
        q0.push_back(mk(1'b0, 13'd1001, 8'h11));
        q1.push_back(mk(1'b0, 13'd1002, 8'h22));
        run_seq();
        // Back-to-back reads on one port.
        q0.push_back(mk(1'b0, 13'd1003, 8'h00));
        q0.push_back(mk(1'b0, 13'd1004, 8'h00));
        run_seq();
        // Both ports requesting continuously from a fresh reset.
        do_reset();
        q0.push_back(mk(1'b0, 13'd1005, 8'h01));
        q0.push_back(mk(1'b0, 13'd1006, 8'h02));
        q1.push_back(mk(1'b0, 13'd1007, 8'h03));
        q1.push_back(mk(1'b0, 13'd1008, 8'h04));
        run_seq();

        // Random mixes over a small address window to create read-after-write hazards.
        for (int it = 0; it < 20; it++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int j = 0; j < n0; j++)
                q0.push_back(mk(1'($urandom_range(0, 1)), 13'd1000 + 13'($urandom_range(0, 7)), 8'($urandom)));
            for (int j = 0; j < n1; j++)
                q1.push_back(mk(1'($urandom_range(0, 1)), 13'd1000 + 13'($urandom_range(0, 7)), 8'($urandom)));
            run_seq();
        end

        // Reset while memWrite is high.
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'd3000; wdata0 = 8'h5C;
        tick();
        check("wr_memWrite", memWrite, 1'b1);
        check("wr_addressMem", addressMem, 13'd3000);
        req0 = 1'b0;
        reset = 1'b1;
        tick();
        shadow[3000] = 8'h5C;
        check("rstwr_memWrite", memWrite, 1'b0);
        check("rstwr_addr_held", addressMem, 13'd3000);
        check("rstwr_ack0", ack0, 1'b0);
        check("rstwr_busy", busy, 1'b0);
        tick();
        check("rstwr2_addr_clear", addressMem, 13'd0);
        check("rstwr2_memWrite", memWrite, 1'b0);
        check("rstwr2_ack0", ack0, 1'b0);
        check("rstwr2_busy", busy, 1'b0);
        reset = 1'b0;
        model_last = 1'b1;
        last_rd = 8'd0;
        rd_known = 1'b1;
        tick();
        check("post_rst_ack0", ack0, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        q1.push_back(mk(1'b0, 13'd3000, 8'h00));
        run_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
